// File: rtl/pbl_pkg.sv
// Shared types and board geometry for the naval-battle controller.
// Cell (r,c) lives at bit 34-5r-c of every 35-bit board vector.
package pbl_pkg;
    localparam int ROWS  = 7;
    localparam int COLS  = 5;
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MISS    = 3'd1,
        ST_HIT     = 3'd2,
        ST_REPEAT  = 3'd3,
        ST_INVALID = 3'd4,
        ST_WIN     = 3'd5,
        ST_LOSE    = 3'd6
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OVER  = 2'd2
    } state_e;

    // Only meaningful for in-range coordinates; callers guard out-of-range ones.
    function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
        return 6'(CELLS - 1 - COLS * int'(r) - int'(c));
    endfunction
endpackage

// File: rtl/modulo_sincroniza_botao.sv
// Two-flop synchroniser for an asynchronous button, plus a delay flop that
// turns each rising edge into a single-cycle fire pulse.
module modulo_sincroniza_botao (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic fire
);
    logic sync1, sync2, dly;

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign fire = sync2 & ~dly;
endmodule

// File: rtl/modulo_controle_jogo.sv
// Naval-battle game controller: shot validation and scoring against the ship
// matrix, shot counter, win/lose detection, and display/LED scan selects.
module modulo_controle_jogo
    import pbl_pkg::*;
#(
    parameter int MAX_SHOTS = 15,
    parameter int SCAN_DIV  = 50000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_confirm,
    input  logic [5:0]  coord,
    input  logic [34:0] m_po,
    output logic [34:0] m_at,
    output logic [2:0]  status,
    output logic [4:0]  shots_left,
    output logic        game_over,
    output logic [1:0]  digit_sel,
    output logic [2:0]  row_sel,
    output logic [4:0]  row_po,
    output logic [4:0]  row_at
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    logic        fire;
    state_e      state, state_n;
    status_e     status_q, status_n;
    logic [34:0] m_at_n;
    logic [4:0]  shots_n;
    logic [5:0]  coord_q, coord_n;
    logic [PW-1:0] presc;

    modulo_sincroniza_botao u_sync (
        .clk  (clk),
        .clr  (clr),
        .btn  (btn_confirm),
        .fire (fire)
    );

    logic [2:0] shot_r, shot_c;
    logic [5:0] shot_idx;
    logic       shot_ok;
    assign shot_r   = coord_q[5:3];
    assign shot_c   = coord_q[2:0];
    assign shot_ok  = (shot_r <= 3'd6) && (shot_c <= 3'd4);
    assign shot_idx = cell_idx(shot_r, shot_c);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= S_IDLE;
            status_q   <= ST_IDLE;
            m_at       <= '0;
            shots_left <= 5'(MAX_SHOTS);
            game_over  <= 1'b0;
            coord_q    <= '0;
        end else begin
            state      <= state_n;
            status_q   <= status_n;
            m_at       <= m_at_n;
            shots_left <= shots_n;
            game_over  <= (state_n == S_OVER);
            coord_q    <= coord_n;
        end
    end

    always_comb begin
        state_n  = state;
        status_n = status_q;
        m_at_n   = m_at;
        shots_n  = shots_left;
        coord_n  = coord_q;
        case (state)
            S_IDLE: begin
                if (fire) begin
                    state_n = S_CHECK;
                    coord_n = coord;
                end
            end
            S_CHECK: begin
                state_n = S_IDLE;
                if (!shot_ok) begin
                    status_n = ST_INVALID;
                end else if (m_at[shot_idx]) begin
                    status_n = ST_REPEAT;
                end else begin
                    m_at_n[shot_idx] = 1'b1;
                    shots_n  = shots_left - 5'd1;
                    status_n = m_po[shot_idx] ? ST_HIT : ST_MISS;
                    // Sinking the last ship on the final shot counts as a win.
                    if ((m_po & ~m_at_n) == '0) begin
                        status_n = ST_WIN;
                        state_n  = S_OVER;
                    end else if (shots_n == 5'd0) begin
                        status_n = ST_LOSE;
                        state_n  = S_OVER;
                    end
                end
            end
            S_OVER:  state_n = S_OVER;
            default: state_n = S_IDLE;
        endcase
    end

    // Scan runs regardless of game state.
    always_ff @(posedge clk) begin
        if (!clr) begin
            presc     <= '0;
            digit_sel <= 2'd0;
            row_sel   <= 3'd0;
        end else if (presc == PRESC_TC) begin
            presc     <= '0;
            digit_sel <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
            row_sel   <= (row_sel == 3'd6) ? 3'd0 : row_sel + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    logic [5:0] row_base;
    assign row_base = cell_idx(row_sel, 3'd0);
    assign row_po   = m_po[row_base -: 5];
    assign row_at   = m_at[row_base -: 5];
    assign status   = status_q;
endmodule
